// File: rtl/key8_pkg.sv
// Shared state encoding and bit-pattern helpers for the 8-key one-hot scanner.
package key8_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  function automatic logic onehot_check(input logic [7:0] v);
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'd0, v[i]};
    end
    return (ones == 4'd1);
  endfunction

  // Isolates the lowest-index set bit (two's-complement trick).
  function automatic logic [7:0] lowest_bit(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

endpackage

// File: rtl/key8_onehot_scan_if.sv
// Key-level bundle between the raw button inputs, the scanner and the downstream encoder.
interface key8_onehot_scan_if;

  logic [7:0] key_in;
  logic [7:0] q;
  logic       q_valid;
  logic       busy;
  logic       err;

  modport master (
    output key_in,
    input  q,
    input  q_valid,
    input  busy,
    input  err
  );

  modport slave (
    input  key_in,
    output q,
    output q_valid,
    output busy,
    output err
  );

endinterface

// File: rtl/key8_sync.sv
// Two-flop synchronizer bringing the asynchronous 8 key levels into the clk domain.
module key8_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] meta_r;
  logic [7:0] sync_r;

  // Metastability-settling flop pair, cleared to 0 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 8'd0;
      sync_r <= 8'd0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/key8_onehot_scan.sv
// Debounced 8-key scanner producing a one-hot q with single-cycle q_valid/err strobes.
// Build option KEY8_PRIORITY_EN: accept multi-key patterns as their lowest-index key.
module key8_onehot_scan
  import key8_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CW         = 8
) (
  input logic              clk,
  input logic              rst_n,
  key8_onehot_scan_if.slave bus
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

  logic [7:0]    ks_s;
  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [7:0]    cap_r, cap_s;
  logic [7:0]    q_r, q_s;
  logic          q_valid_r, q_valid_s;
  logic          err_r, err_s;
  logic          busy_r;

  key8_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.key_in),
    .q     (ks_s)
  );

  // Next-state, counter, capture and output-strobe decisions.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    cap_s     = cap_r;
    q_s       = q_r;
    q_valid_s = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (ks_s != 8'd0) begin
          state_s = DEBOUNCE;
          cap_s   = ks_s;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      DEBOUNCE: begin
        if (ks_s == 8'd0) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else if (ks_s != cap_r) begin
          cap_s = ks_s;
          cnt_s = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          cnt_s = CNT_ZERO;
`ifdef KEY8_PRIORITY_EN
          q_s       = lowest_bit(cap_r);
          q_valid_s = 1'b1;
          state_s   = HOLD;
`else
          if (onehot_check(cap_r)) begin
            q_s       = cap_r;
            q_valid_s = 1'b1;
            state_s   = HOLD;
          end else begin
            // Rejected chord: q stays 0 and we still wait for a clean release.
            q_s     = 8'd0;
            err_s   = 1'b1;
            state_s = RELEASE;
          end
`endif
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      HOLD: begin
        if (ks_s == 8'd0) begin
          state_s = RELEASE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = HOLD;
        end
      end
      RELEASE: begin
        if (ks_s != 8'd0) begin
          cnt_s = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          q_s     = 8'd0;
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        q_s     = 8'd0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      cap_r     <= 8'd0;
      q_r       <= 8'd0;
      q_valid_r <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      cap_r     <= cap_s;
      q_r       <= q_s;
      q_valid_r <= q_valid_s;
      err_r     <= err_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.err     = err_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_key8_onehot_scan.sv
// Self-checking bench for key8_onehot_scan: segment table, timing sequences, random run vs run-length model.
module tb_key8_onehot_scan;

  localparam int DEB = 4;

  logic clk;
  logic rst_n;

  key8_onehot_scan_if bus ();

  key8_onehot_scan #(.DEB_CYCLES(DEB), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int seg_valid = 0;
  int seg_err = 0;

  // Reference model: input delay line plus run-length rules.
  logic [7:0] m_pipe0, m_pipe1, m_prev, m_q;
  logic       m_valid, m_err, m_busy, m_free, m_holding;
  int         m_run, m_zrun;

  typedef struct {
    logic [7:0] key;
    int         cycles;
    logic [7:0] exp_q;
    int         exp_valid;
    int         exp_err;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pipe0 = 8'd0; m_pipe1 = 8'd0; m_prev = 8'd0; m_q = 8'd0;
    m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    m_free = 1'b1; m_holding = 1'b0; m_run = 0; m_zrun = 0;
  endtask

  task automatic model_step(input logic [7:0] k);
    logic [7:0] s;
    logic [7:0] lb;
    s = m_pipe1;
    m_valid = 1'b0;
    m_err = 1'b0;
    if (m_free) begin
      // Count identical nonzero synced samples; DEB+1 in a row means accepted.
      if (s == 8'd0) m_run = 0;
      else if (m_run > 0 && s == m_prev) m_run++;
      else m_run = 1;
      m_prev = s;
      if (m_run == DEB + 1) begin
        m_run = 0;
        m_free = 1'b0;
        if ($countones(s) == 1) begin
          m_q = s; m_valid = 1'b1; m_holding = 1'b1;
        end else begin
`ifdef KEY8_PRIORITY_EN
          lb = 8'd0;
          for (int i = 7; i >= 0; i--) if (s[i]) lb = 8'd1 << i;
          m_q = lb; m_valid = 1'b1; m_holding = 1'b1;
`else
          lb = 8'd0;
          m_q = lb; m_err = 1'b1; m_holding = 1'b0; m_zrun = 0;
`endif
        end
      end
    end else if (m_holding) begin
      if (s == 8'd0) begin
        m_holding = 1'b0;
        m_zrun = 0;
      end
    end else begin
      if (s != 8'd0) m_zrun = 0;
      else begin
        m_zrun++;
        if (m_zrun == DEB) begin
          m_q = 8'd0; m_free = 1'b1; m_run = 0;
        end
      end
    end
    m_busy = !m_free || (m_run > 0);
    m_pipe1 = m_pipe0;
    m_pipe0 = k;
  endtask

  task automatic tick(input logic [7:0] k);
    bus.key_in = k;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(k);
    #1;
    if (bus.q_valid) seg_valid++;
    if (bus.err) seg_err++;
    check("cycle_model", 32'({bus.q, bus.q_valid, bus.err, bus.busy}),
          32'({m_q, m_valid, m_err, m_busy}));
  endtask

  initial begin
    int rows;
    int pulses;
    logic [7:0] k;
    bus.key_in = 8'd0;
    rst_n = 1'b0;
    model_reset();

    tbl[0] = '{8'h04, 20, 8'h04, 1, 0};
    tbl[1] = '{8'h00, 20, 8'h00, 0, 0};
`ifdef KEY8_PRIORITY_EN
    tbl[2] = '{8'h24, 20, 8'h04, 1, 0};
`else
    tbl[2] = '{8'h24, 20, 8'h00, 0, 1};
`endif
    tbl[3] = '{8'h00, 20, 8'h00, 0, 0};
    for (int i = 0; i < 8; i++) begin
      tbl[4 + 2 * i] = '{8'd1 << i, 20, 8'd1 << i, 1, 0};
      tbl[5 + 2 * i] = '{8'h00, 20, 8'h00, 0, 0};
    end
    rows = 20;

    // Reset state.
    tick(8'd0);
    tick(8'd0);
    check("reset_outputs", 32'({bus.q, bus.q_valid, bus.err, bus.busy}), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick(8'd0);

    // Segment table.
    for (int r = 0; r < rows; r++) begin
      seg_valid = 0;
      seg_err = 0;
      for (int c = 0; c < tbl[r].cycles; c++) tick(tbl[r].key);
      check($sformatf("tbl%0d_q", r), 32'(bus.q), 32'(tbl[r].exp_q));
      check($sformatf("tbl%0d_valid_pulses", r), 32'(seg_valid), 32'(tbl[r].exp_valid));
      check($sformatf("tbl%0d_err_pulses", r), 32'(seg_err), 32'(tbl[r].exp_err));
    end

    // Press latency: q appears on the 7th edge, q_valid for one cycle.
    for (int i = 1; i <= 8; i++) begin
      tick(8'h04);
      if (i < 7) check("press_early_q", 32'(bus.q), 32'h0);
      if (i == 7) check("press_q_valid", 32'({bus.q, bus.q_valid, bus.busy}), 32'({8'h04, 1'b1, 1'b1}));
      if (i == 8) check("press_valid_once", 32'(bus.q_valid), 32'h0);
    end
    // Release latency: q clears on the 7th edge with no strobes.
    seg_valid = 0; seg_err = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(8'h00);
      if (i < 7) check("release_early_q", 32'(bus.q), 32'h04);
      if (i == 7) check("release_q", 32'({bus.q, bus.busy}), 32'h0);
    end
    check("release_no_pulses", 32'(seg_valid + seg_err), 32'h0);

    // Bounce: two-cycle toggles never long enough to accept.
    for (int i = 0; i < 10; i++) begin
      tick(((i / 2) % 2 == 1) ? 8'h10 : 8'h00);
      check("bounce_q", 32'(bus.q), 32'h0);
    end
    for (int i = 1; i <= 8; i++) begin
      tick(8'h10);
      if (i < 7) check("bounce_hold_early_q", 32'(bus.q), 32'h0);
      if (i == 7) check("bounce_hold_q", 32'(bus.q), 32'h10);
    end
    for (int i = 0; i < 20; i++) tick(8'h00);

    // Reset mid-debounce, then full latency again from reset release.
    for (int i = 0; i < 5; i++) tick(8'h80);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_outputs", 32'({bus.q, bus.q_valid, bus.err, bus.busy}), 32'd0);
    tick(8'h80);
    tick(8'h80);
    #2 rst_n = 1'b1;
    seg_valid = 0; seg_err = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(8'h80);
      if (i < 7) check("post_reset_early_q", 32'(bus.q), 32'h0);
      if (i == 7) check("post_reset_q", 32'({bus.q, bus.q_valid}), 32'({8'h80, 1'b1}));
    end
    check("post_reset_one_valid", 32'(seg_valid), 32'd1);
    for (int i = 0; i < 20; i++) tick(8'h00);

    // Random runs of idle, single keys and chords against the model.
    pulses = 0;
    for (int s = 0; s < 150; s++) begin
      case ($urandom_range(0, 3))
        0: k = 8'h00;
        1, 2: k = 8'd1 << $urandom_range(0, 7);
        default: k = 8'($urandom);
      endcase
      for (int c = 0, len = int'($urandom_range(1, 12)); c < len; c++) begin
        tick(k);
        if (bus.q_valid && bus.err) pulses++;
      end
    end
    check("valid_err_exclusive", 32'(pulses), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
